// File: rtl/maq_troco.sv
// Coin dispenser controller: returns change as active-low coin pulses
// in greedy order (R$1,00, R$0,50, R$0,25), paced by the dispenser ready.
module maq_troco #(
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] i_credito,
  input  logic       i_pronto,
  output logic       o_moeda_1,
  output logic       o_moeda_50,
  output logic       o_moeda_25,
  output logic       o_ocupado,
  output logic       o_fim,
  output logic [3:0] o_restante
);

  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_LEN - 1);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       coins, coins_nx;
  logic [3:0]       restante, restante_nx;
  logic             ocupado, ocupado_nx;
  logic             fim, fim_nx;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      coins    <= 3'b111;
      restante <= 4'd0;
      ocupado  <= 1'b0;
      fim      <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      coins    <= coins_nx;
      restante <= restante_nx;
      ocupado  <= ocupado_nx;
      fim      <= fim_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    coins_nx    = coins;
    restante_nx = restante;
    ocupado_nx  = ocupado;
    fim_nx      = 1'b0;
    case (state)
      IDLE: begin
        coins_nx   = 3'b111;
        ocupado_nx = 1'b0;
        if (i_start) begin
          restante_nx = i_credito;
          ocupado_nx  = 1'b1;
          state_nx    = SELECT;
        end
      end
      SELECT: begin
        if (restante == 4'd0) begin
          fim_nx     = 1'b1;
          ocupado_nx = 1'b0;
          state_nx   = DONE;
        end else if (i_pronto) begin
          // Greedy pick; the chosen coin never exceeds what remains
          if (restante >= 4'd4) begin
            coins_nx    = 3'b011;
            restante_nx = restante - 4'd4;
          end else if (restante >= 4'd2) begin
            coins_nx    = 3'b101;
            restante_nx = restante - 4'd2;
          end else begin
            coins_nx    = 3'b110;
            restante_nx = restante - 4'd1;
          end
          cnt_nx   = PULSE_LOAD;
          state_nx = PULSE;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          coins_nx = 3'b111;
          cnt_nx   = GAP_LOAD;
          state_nx = GAP;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) state_nx = SELECT;
        else           cnt_nx   = cnt - 1'b1;
      end
      DONE: begin
        ocupado_nx = 1'b0;
        state_nx   = IDLE;
      end
      default: begin
        coins_nx   = 3'b111;
        ocupado_nx = 1'b0;
        state_nx   = IDLE;
      end
    endcase
  end

  assign o_moeda_1  = coins[2];
  assign o_moeda_50 = coins[1];
  assign o_moeda_25 = coins[0];
  assign o_ocupado  = ocupado;
  assign o_fim      = fim;
  assign o_restante = restante;

endmodule
